// File: rtl/fwrisc_trace_pkg.sv
// Shared types for the retirement-trace packer: record layout, header bit
// positions, field byte counts, serialiser states and byte-select helpers.
package fwrisc_trace_pkg;

    localparam int HDR_BIT_MARK = 7;
    localparam int HDR_BIT_OVF  = 6;
    localparam int HDR_BIT_RDP  = 5;
    localparam int HDR_BIT_MEMP = 4;
    localparam int HDR_BIT_MW   = 3;

    localparam int WORD_BYTES = 4;
    localparam int RD_BYTES   = 5;
    localparam int MEM_BYTES  = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_INSTR,
        S_RD,
        S_MEM
    } ser_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  rd_waddr;
        logic [31:0] rd_wdata;
`ifdef FWRISC_TRACE_MEM_EN
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [3:0]  mstrb;
        logic        memp;
        logic        mw;
`endif
        logic        rdp;
        logic        ovf;
    } trace_rec_t;

    function automatic logic rec_memp(trace_rec_t r);
`ifdef FWRISC_TRACE_MEM_EN
        return r.memp;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] rec_header(trace_rec_t r);
        logic [7:0] h;
        h = '0;
        h[HDR_BIT_MARK] = 1'b1;
        h[HDR_BIT_OVF]  = r.ovf;
        h[HDR_BIT_RDP]  = r.rdp;
`ifdef FWRISC_TRACE_MEM_EN
        h[HDR_BIT_MEMP] = r.memp;
        h[HDR_BIT_MW]   = r.mw;
`endif
        return h;
    endfunction

    function automatic logic [7:0] word_byte(logic [31:0] w, logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // Byte emitted while the serialiser sits in state s at index i.
    function automatic logic [7:0] rec_byte(trace_rec_t r, ser_state_t s, logic [3:0] i);
        logic [7:0] b;
        b = '0;
        case (s)
            S_HDR:   b = rec_header(r);
            S_PC:    b = word_byte(r.pc, i[1:0]);
            S_INSTR: b = word_byte(r.instr, i[1:0]);
            S_RD:    b = (i == 4'd0) ? {2'b00, r.rd_waddr} : word_byte(r.rd_wdata, 2'(i - 4'd1));
`ifdef FWRISC_TRACE_MEM_EN
            S_MEM: begin
                if (i < 4'd4)      b = word_byte(r.maddr, i[1:0]);
                else if (i < 4'd8) b = word_byte(r.mdata, i[1:0]);
                else               b = {4'b0000, r.mstrb};
            end
`endif
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// Record FIFO for the trace packer; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module fwrisc_trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rp[AW-1:0]];
    assign o_count = r_wp - r_rp;
    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

endmodule

// File: rtl/fwrisc_trace_packer.sv
// Captures one record per retired instruction and serialises it as a byte packet.
// Define FWRISC_TRACE_MEM_EN to include memory-access fields in the packets.
module fwrisc_trace_packer
    import fwrisc_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ivalid,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [5:0]  rd_waddr,
    input  logic [31:0] rd_wdata,
    input  logic        rd_write,
    input  logic [31:0] maddr,
    input  logic [31:0] mdata,
    input  logic [3:0]  mstrb,
    input  logic        mwrite,
    input  logic        mvalid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] drop_count,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $bits(trace_rec_t);
    localparam logic [3:0] LAST_WORD = 4'(WORD_BYTES - 1);
    localparam logic [3:0] LAST_RD   = 4'(RD_BYTES - 1);
    localparam logic [3:0] LAST_MEM  = 4'(MEM_BYTES - 1);

    trace_rec_t    w_new;
    trace_rec_t    w_head;
    trace_rec_t    r_rec;
    logic [RW-1:0] w_head_bits;
    logic          w_full, w_empty, w_push, w_pop, w_drop, w_adv, w_last;
    logic [CW-1:0] w_count, w_count_next;
    ser_state_t    r_state, w_state_next;
    logic [3:0]    r_idx, w_idx_next;
    logic          r_ovf;

`ifdef FWRISC_TRACE_MEM_EN
    logic        r_pend, r_pwrite;
    logic [31:0] r_paddr, r_pdata;
    logic [3:0]  r_pstrb;

    // Any retirement consumes the pending access, even a dropped one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend   <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pdata  <= '0;
            r_pstrb  <= '0;
        end else if (ivalid) begin
            r_pend <= 1'b0;
        end else if (mvalid) begin
            r_pend   <= 1'b1;
            r_pwrite <= mwrite;
            r_paddr  <= maddr;
            r_pdata  <= mdata;
            r_pstrb  <= mstrb;
        end
    end
`else
    logic w_unused_mem;
    assign w_unused_mem = ^{maddr, mdata, mstrb, mwrite, mvalid};
`endif

    always_comb begin
        w_new          = '0;
        w_new.pc       = pc;
        w_new.instr    = instr;
        w_new.rd_waddr = rd_waddr;
        w_new.rd_wdata = rd_wdata;
        w_new.rdp      = rd_write && (rd_waddr != 6'd0);
        w_new.ovf      = r_ovf;
`ifdef FWRISC_TRACE_MEM_EN
        if (mvalid) begin
            w_new.memp  = 1'b1;
            w_new.mw    = mwrite;
            w_new.maddr = maddr;
            w_new.mdata = mdata;
            w_new.mstrb = mstrb;
        end else if (r_pend) begin
            w_new.memp  = 1'b1;
            w_new.mw    = r_pwrite;
            w_new.maddr = r_paddr;
            w_new.mdata = r_pdata;
            w_new.mstrb = r_pstrb;
        end
`endif
    end

    // A full FIFO still accepts when the last byte pops the head this cycle.
    assign w_push       = ivalid && (!w_full || w_pop);
    assign w_drop       = ivalid && !w_push;
    assign w_pop        = w_last;
    assign w_adv        = tx_valid && tx_ready;
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    assign w_head       = trace_rec_t'(w_head_bits);

    fwrisc_trace_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_wdata (w_new),
        .i_pop   (w_pop),
        .o_rdata (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf      <= 1'b0;
            drop_count <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else if (w_push) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_state_next = S_HDR;
                w_idx_next   = '0;
            end
            S_HDR: if (w_adv) begin
                w_state_next = S_PC;
                w_idx_next   = '0;
            end
            S_PC: if (w_adv) begin
                if (r_idx == LAST_WORD) begin
                    w_state_next = S_INSTR;
                    w_idx_next   = '0;
                end else w_idx_next = r_idx + 4'd1;
            end
            S_INSTR: if (w_adv) begin
                if (r_idx == LAST_WORD) begin
                    w_idx_next = '0;
                    if (r_rec.rdp)               w_state_next = S_RD;
                    else if (rec_memp(r_rec))    w_state_next = S_MEM;
                    else begin
                        w_state_next = S_IDLE;
                        w_last       = 1'b1;
                    end
                end else w_idx_next = r_idx + 4'd1;
            end
            S_RD: if (w_adv) begin
                if (r_idx == LAST_RD) begin
                    w_idx_next = '0;
                    if (rec_memp(r_rec)) w_state_next = S_MEM;
                    else begin
                        w_state_next = S_IDLE;
                        w_last       = 1'b1;
                    end
                end else w_idx_next = r_idx + 4'd1;
            end
            S_MEM: if (w_adv) begin
                if (r_idx == LAST_MEM) begin
                    w_idx_next   = '0;
                    w_state_next = S_IDLE;
                    w_last       = 1'b1;
                end else w_idx_next = r_idx + 4'd1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // tx_data is preloaded with the byte of the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_rec    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            busy    <= (w_count_next != '0) || (w_state_next != S_IDLE);
            if (r_state == S_IDLE) begin
                if (!w_empty) begin
                    r_rec    <= w_head;
                    tx_data  <= rec_header(w_head);
                    tx_valid <= 1'b1;
                end
            end else if (w_adv) begin
                if (w_last) begin
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                end else begin
                    tx_data <= rec_byte(r_rec, w_state_next, w_idx_next);
                end
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_trace_packer.sv
// Bench for fwrisc_trace_packer: directed vector table, multi-cycle sequences and
// randomized traffic against a packet-level model. Honors FWRISC_TRACE_MEM_EN.
module tb_fwrisc_trace_packer;
    localparam int DEPTH = 4;

    logic        clock, reset, ivalid, rd_write, mwrite, mvalid, tx_valid, tx_ready, busy;
    logic [31:0] pc, instr, rd_wdata, maddr, mdata;
    logic [5:0]  rd_waddr;
    logic [3:0]  mstrb;
    logic [7:0]  tx_data;
    logic [15:0] drop_count;

    fwrisc_trace_packer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .pc(pc), .instr(instr),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
        .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite), .mvalid(mvalid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .drop_count(drop_count), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
    initial begin
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         len_q[$];
    int         cur_bytes = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, stall_data});
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (exp_q.size() == 0) check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                else check("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                cur_bytes++;
                if (len_q.size() > 0 && cur_bytes == len_q[0]) begin
                    void'(len_q.pop_front());
                    cur_bytes = 0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic        m_pend = 1'b0, m_mw = 1'b0, m_ovf = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_strb = '0;

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(w >> (8 * k)));
    endtask

    task automatic build_packet(input logic [31:0] ipc, iins, input logic rdp, input logic [5:0] rda,
                                input logic [31:0] rdd, input logic memp, mw, input logic [31:0] ma, md,
                                input logic [3:0] ms, input logic ovf);
        logic [7:0] hdr;
        hdr = 8'h80;
        if (ovf)         hdr = hdr + 8'h40;
        if (rdp)         hdr = hdr + 8'h20;
        if (memp)        hdr = hdr + 8'h10;
        if (memp && mw)  hdr = hdr + 8'h08;
        exp_q.push_back(hdr);
        push_word(ipc);
        push_word(iins);
        if (rdp) begin
            exp_q.push_back({2'b00, rda});
            push_word(rdd);
        end
        if (memp) begin
            push_word(ma);
            push_word(md);
            exp_q.push_back({4'h0, ms});
        end
        len_q.push_back(9 + (rdp ? 5 : 0) + (memp ? 9 : 0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic mem_cycle(input logic mwr, input logic [31:0] ma, md, input logic [3:0] ms);
`ifdef FWRISC_TRACE_MEM_EN
        m_pend = 1'b1; m_mw = mwr; m_addr = ma; m_data = md; m_strb = ms;
`endif
        mvalid = 1'b1; mwrite = mwr; maddr = ma; mdata = md; mstrb = ms;
        @(posedge clock); #1;
        mvalid = 1'b0;
    endtask

    task automatic instr_cycle(input logic [31:0] ipc, iins, input logic rdw, input logic [5:0] rda,
                               input logic [31:0] rdd, input logic mv, mwr, input logic [31:0] ma, md,
                               input logic [3:0] ms, input logic drop);
        logic memp, mw_m;
        logic [31:0] ea, ed;
        logic [3:0] es;
        memp = 1'b0; mw_m = 1'b0; ea = '0; ed = '0; es = '0;
`ifdef FWRISC_TRACE_MEM_EN
        if (mv) begin
            memp = 1'b1; mw_m = mwr; ea = ma; ed = md; es = ms;
        end else if (m_pend) begin
            memp = 1'b1; mw_m = m_mw; ea = m_addr; ed = m_data; es = m_strb;
        end
        m_pend = 1'b0;
`endif
        if (drop) m_ovf = 1'b1;
        else begin
            build_packet(ipc, iins, rdw && (rda != 6'd0), rda, rdd, memp, mw_m, ea, ed, es, m_ovf);
            m_ovf = 1'b0;
        end
        ivalid = 1'b1; pc = ipc; instr = iins; rd_write = rdw; rd_waddr = rda; rd_wdata = rdd;
        mvalid = mv; mwrite = mwr; maddr = ma; mdata = md; mstrb = ms;
        @(posedge clock); #1;
        ivalid = 1'b0; rd_write = 1'b0; mvalid = 1'b0;
    endtask

    task automatic simple_instr(input logic [31:0] ipc, iins, input logic drop);
        instr_cycle(ipc, iins, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, drop);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clock); #1;
            n++;
        end while (!(exp_q.size() == 0 && !busy) && n < 3000);
        check(name, {31'd0, exp_q.size() == 0 && !busy}, 32'd1);
    endtask

    function automatic logic [7:0] got_at(input int i);
        return (got_q.size() > i) ? got_q[i] : 8'h00;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rdw;
        logic [5:0]  rda;
        logic [31:0] rdd;
        logic [7:0]  exp_hdr;
        int          exp_len;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 6'd0,  32'h0000_0000, 8'h80, 9};
        vecs[1] = '{32'h8000_0004, 32'h0050_0293, 1'b1, 6'd5,  32'h1234_5678, 8'hA0, 14};
        vecs[2] = '{32'h8000_0008, 32'h0000_0013, 1'b1, 6'd0,  32'h1234_5678, 8'h80, 9};
        vecs[3] = '{32'h8000_000C, 32'hFFF0_0F93, 1'b1, 6'd31, 32'hCAFE_F00D, 8'hA0, 14};
        vecs[4] = '{32'h8000_0010, 32'h0070_0393, 1'b0, 6'd7,  32'h0000_0001, 8'h80, 9};
        vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 6'd63, 32'hFFFF_FFFF, 8'hA0, 14};

        ivalid = 0; pc = 0; instr = 0; rd_waddr = 0; rd_wdata = 0; rd_write = 0;
        maddr = 0; mdata = 0; mstrb = 0; mwrite = 0; mvalid = 0; tx_ready = 1'b1;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        idle_cycles(2);

        // Latency: record after edge N, header valid after N+1.
        got_q.delete();
        simple_instr(32'h8000_0000, 32'h0000_0013, 1'b0);
        check("lat_n_valid", {31'd0, tx_valid}, 32'd0);
        check("lat_n_busy", {31'd0, busy}, 32'd1);
        @(posedge clock); #1;
        check("lat_hdr_valid", {31'd0, tx_valid}, 32'd1);
        check("lat_hdr_data", {24'd0, tx_data}, 32'h80);
        wait_drain("lat_drain");
        check("lat_len", got_q.size(), 32'd9);

        // Vector table, first with tx_ready held high then with random backpressure.
        for (int p = 0; p < 2; p++) begin
            ready_mode = (p == 0) ? 1 : 2;
            for (int v = 0; v < 6; v++) begin
                got_q.delete();
                instr_cycle(vecs[v].pc, vecs[v].instr, vecs[v].rdw, vecs[v].rda, vecs[v].rdd,
                            1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
                wait_drain("vec_drain");
                check("vec_hdr", {24'd0, got_at(0)}, {24'd0, vecs[v].exp_hdr});
                check("vec_len", got_q.size(), vecs[v].exp_len);
            end
        end

        // Back-to-back packets: 18 bytes with a single idle gap.
        ready_mode = 1;
        idle_cycles(2);
        simple_instr(32'h8000_0100, 32'h0000_0013, 1'b0);
        simple_instr(32'h8000_0104, 32'h0000_0013, 1'b0);
        begin
            int first, last, nvalid;
            first = -1; last = -1; nvalid = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clock); #1;
                if (tx_valid) begin
                    if (first < 0) first = c;
                    last = c;
                    nvalid++;
                end
            end
            check("bubble_span", last - first + 1, 32'd19);
            check("bubble_valid", nvalid, 32'd18);
        end
        wait_drain("bubble_drain");

        // Pending memory access consumed three cycles later.
        got_q.delete();
        mem_cycle(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        idle_cycles(2);
        simple_instr(32'h8000_0200, 32'h00F1_2023, 1'b0);
        wait_drain("mem_drain");
`ifdef FWRISC_TRACE_MEM_EN
        check("mem_hdr", {24'd0, got_at(0)}, 32'h98);
        check("mem_len", got_q.size(), 32'd18);
`else
        check("mem_hdr", {24'd0, got_at(0)}, 32'h80);
        check("mem_len", got_q.size(), 32'd9);
`endif
        got_q.delete();
        simple_instr(32'h8000_0204, 32'h0000_0013, 1'b0);
        wait_drain("mem_next_drain");
        check("mem_next_hdr", {24'd0, got_at(0)}, 32'h80);

        // Overflow: six retirements with the sink stalled.
        ready_mode = 0;
        idle_cycles(2);
        got_q.delete();
        for (int k = 0; k < 6; k++) simple_instr(32'h8000_0300 + 32'(4 * k), 32'h0000_0013, k >= 4);
        check("ovf_drop_count", {16'd0, drop_count}, 32'd2);
        idle_cycles(4);
        ready_mode = 1;
        wait_drain("ovf_drain");
        check("ovf_len", got_q.size(), 32'd36);
        for (int k = 0; k < 4; k++) check("ovf_early_hdr", {24'd0, got_at(9 * k)}, 32'h80);
        got_q.delete();
        simple_instr(32'h8000_0400, 32'h0000_0013, 1'b0);
        wait_drain("ovf7_drain");
        check("ovf7_hdr", {24'd0, got_at(0)}, 32'hC0);
        check("ovf_drop_hold", {16'd0, drop_count}, 32'd2);

        // Random traffic with random backpressure; FIFO kept from overflowing.
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            int r;
            for (int b = 0; b < 1000 && len_q.size() >= DEPTH; b++) idle_cycles(1);
            r = $urandom_range(0, 3);
            if (r == 1) mem_cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            if (r == 2) begin
                mem_cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                mem_cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            idle_cycles($urandom_range(0, 3));
            instr_cycle($urandom, $urandom, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)), $urandom,
                        r == 3, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        4'($urandom_range(0, 15)), 1'b0);
        end
        wait_drain("rand_drain");

        // Reset mid-packet, then recovery.
        ready_mode = 1;
        idle_cycles(2);
        got_q.delete();
        simple_instr(32'h8000_0500, 32'h0000_0013, 1'b0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clock); #2;
                n++;
            end while (got_q.size() < 5 && n < 50);
            check("rst_mid_reached", got_q.size(), 32'd5);
        end
        reset = 1'b1;
        #1;
        check("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_mid_drop", {16'd0, drop_count}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete(); len_q.delete(); cur_bytes = 0;
        m_pend = 1'b0; m_ovf = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        idle_cycles(2);
        got_q.delete();
        simple_instr(32'h8000_0600, 32'h0000_0013, 1'b0);
        wait_drain("rst_after_drain");
        check("rst_after_hdr", {24'd0, got_at(0)}, 32'h80);
        check("rst_after_len", got_q.size(), 32'd9);
        check("final_drop", {16'd0, drop_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwrisc_trace_packer.md
# fwrisc_trace_packer

Downstream consumer of the core's retirement-trace signals: the same instruction/register/memory taps the tracer attachment point exposes. It captures one record per retired instruction into a small FIFO and serialises each record as a variable-length byte packet on a valid/ready byte stream. The stream is intended to feed the UART transmitter, so tests can log instruction traces off-chip without a simulator-side BFM.

## Interface
- `DEPTH`, default 4: record FIFO depth; power of two, ≥2.
- `clock` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `ivalid` in 1: instruction retires this cycle; capture a record.
- `pc` in 32: PC of the retiring instruction.
- `instr` in 32: instruction word.
- `rd_waddr` in 6: destination register index.
- `rd_wdata` in 32: write-back data.
- `rd_write` in 1: write-back occurs this cycle.
- `maddr` in 32: memory access address.
- `mdata` in 32: memory data (store data or load return).
- `mstrb` in 4: byte strobes.
- `mwrite` in 1: access is a store.
- `mvalid` in 1: memory access completes this cycle.
- `tx_data` out 8: stream byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts the byte.
- `drop_count` out 16: count of records dropped on a full FIFO; saturates at 0xFFFF.
- `busy` out 1: FIFO non-empty or packet in flight.

## Operation
- Record contents: pc, instr, rd fields, mem fields, plus four flags: rdp, memp, mw, ovf.
- rdp = `rd_write && rd_waddr != 0`. x0 writes are never reported.
- Pending-mem register: loaded on `mvalid` with maddr, mdata, mstrb, mwrite.
  - The next `ivalid` consumes it (sets memp = 1) and clears it.
  - If `mvalid` and `ivalid` occur in the same cycle, the current cycle's access is used directly.
  - A second `mvalid` before `ivalid` overwrites the pending access.
- Overflow: `ivalid` with the FIFO full drops the record.
  - `drop_count` increments (saturating) and a sticky ovf flag sets.
  - The next accepted record carries ovf = 1, and the sticky flag clears.
- FIFO write and pop in the same cycle while full: the write is accepted.
- Packet byte order; multi-byte fields are sent LSB first:
  - Header: bit7 = 1, bit6 = ovf, bit5 = rdp, bit4 = memp, bit3 = mw, bits[2:0] = 0.
  - pc (4 bytes), then instr (4 bytes).
  - If rdp: `{2'b0, rd_waddr}`, then rd_wdata (4 bytes).
  - If memp: maddr (4 bytes), mdata (4 bytes), then `{4'b0, mstrb}`.
- Packet lengths: 9, 14, 18 or 23 bytes.
- Serialiser FSM states: IDLE, HDR, PC, INSTR, RD, MEM.
  - A 2-bit byte index walks each 4-byte field; RD and MEM use a 5- and 9-step index respectively.
  - IDLE → HDR when the FIFO is non-empty; the head record is latched into the output register.
  - HDR → PC → INSTR → (RD if rdp) → (MEM if memp) → IDLE.
  - Leaving the last byte pops the FIFO.
  - Fields whose flag is clear are skipped.
- Handshake: the FSM advances only on `tx_valid && tx_ready`.
  - `tx_data` and `tx_valid` stay stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops mid-packet.

## Timing
- Reset values, applied asynchronously and immediately:
  - `tx_valid` = 0, `tx_data` = 0, `drop_count` = 0, `busy` = 0.
  - FIFO empty, FSM in IDLE, pending-mem and sticky ovf cleared.
- Reset mid-packet aborts the packet; no partial resume.
- `ivalid` sampled at edge N: the record is in the FIFO after N. IDLE → HDR at N+1, so the header is on `tx_data` with `tx_valid` = 1 in the cycle after N+1.
- Peak throughput: one byte per cycle within a packet, with exactly one IDLE bubble between packets.
- `busy` is registered and reflects the state after each edge.

## Configuration
- `FWRISC_TRACE_MEM_EN` defined:
  - Pending-mem register and mem FIFO fields are compiled in.
  - memp and mw are reported as described above.
- `FWRISC_TRACE_MEM_EN` undefined:
  - `maddr`, `mdata`, `mstrb`, `mwrite` and `mvalid` are ignored; mem storage is removed.
  - Header bits 4 and 3 are always 0; the MEM state is unreachable and may be removed.
  - Maximum packet length is 14 bytes.

## Structure
- Package `fwrisc_trace_pkg`:
  - Record struct typedef and header bit-position constants.
  - Field byte-count constants.
  - Serialiser state enum.
- Sub-module `fwrisc_trace_fifo`: parameterised on width and DEPTH.
  - Push/pop interface with full/empty outputs.
  - Pointer wrap via extra MSB.

## Test plan
- `ivalid` with pc = 0x80000000, instr = 0x00000013, no rd/mem, `tx_ready` = 1 → bytes 80 00 00 00 80 13 00 00 00, then `busy` = 0.
- `rd_write`, `rd_waddr` = 5, `rd_wdata` = 0x12345678 → header A0, packet ends 05 78 56 34 12 (14 bytes). Repeat with `rd_waddr` = 0 → 9-byte packet, header 80.
- `mvalid`, `mwrite`, maddr = 0x1000, mdata = 0xDEADBEEF, mstrb = 0xF, then `ivalid` 3 cycles later → header 98, 18 bytes ending 00 10 00 00 EF BE AD DE 0F. The next instruction's header has memp = 0.
- DEPTH = 4, `tx_ready` = 0, 6 `ivalid`s → `drop_count` = 2. Drain all; a 7th `ivalid` yields header C0; the first 4 packets have ovf = 0.
- `tx_ready` toggled randomly → `tx_data` never changes while stalled; byte stream identical to the `tx_ready` = 1 run.
- Reset asserted at byte 5 of a packet → `tx_valid` = 0 in the same cycle, `drop_count` = 0. After release, a new `ivalid` emits a complete packet with header 80.
